// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer stage: ALU op/flag encodings,
// sequencer FSM states, reset op constant and the divide-by-zero helper.
package alu_sequencer_pkg;

    // ALU operation select; ALU_NOP lands in the ALU's default case.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_DIV = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_NOP = 3'd7
    } alu_op_e;

    // Single status flag reported by the ALU alongside its result.
    typedef enum logic [1:0] {
        FLAG_NONE      = 2'd0,
        FLAG_CARRY     = 2'd1,
        FLAG_ZERO      = 2'd2,
        FLAG_REMAINDER = 2'd3
    } alu_flag_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } alu_seq_state_e;

    // Op driven to the ALU while no transaction has been accepted yet.
    localparam alu_op_e ALU_OP_RESET = ALU_NOP;

    // Result reported for a trapped divide by zero.
    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    // True when the request is a division whose divisor is zero.
    function automatic logic is_div_by_zero(input alu_op_e op, input logic [7:0] b);
        return (op == ALU_DIV) && (b == 8'h00);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the decoder request, ALU bus and writeback response signals
// around the ALU sequencer. The slave modport is the sequencer's view; the
// master modport is the surrounding decoder/ALU/writeback view.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int DST_W = 2
) ();

    // decoder -> sequencer
    logic             req_valid;
    logic             req_ready;
    alu_op_e          req_op;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [DST_W-1:0] req_dst;

    // sequencer <-> ALU
    logic [7:0]       alu_register1;
    logic [7:0]       alu_register2;
    alu_op_e          alu_op;
    logic             alu_enable;
    logic [7:0]       alu_result;
    alu_flag_e        alu_flag;

    // sequencer -> writeback
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    alu_flag_e        rsp_flag;
    logic [DST_W-1:0] rsp_dst;

    // status
    logic             busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dst,
        output req_ready,
        output alu_register1, alu_register2, alu_op, alu_enable,
        input  alu_result, alu_flag,
        output rsp_valid, rsp_data, rsp_flag, rsp_dst,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_dst,
        input  req_ready,
        input  alu_register1, alu_register2, alu_op, alu_enable,
        output alu_result, alu_flag,
        input  rsp_valid, rsp_data, rsp_flag, rsp_dst,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one op + operands from the decoder, holds them on
// the ALU inputs for LATENCY cycles, enables the shared ALU result bus for a
// single capture cycle and hands result/flag/tag to writeback. One
// transaction in flight at a time.
//
// Optional feature macro: ALU_DIV0_TRAP_EN -- a divide by zero bypasses the
// ALU, answers 8'hFF / FLAG_REMAINDER and pulses div0_trap for one cycle.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The producer holds valid and its payload stable until
// that edge; ready never depends on valid in the same cycle (req_ready is
// high only in IDLE, rsp_valid only in RESP), and payload is sampled only on
// the transfer edge.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DST_W   = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    alu_sequencer_if.slave bus,
`ifdef ALU_DIV0_TRAP_EN
    output logic           div0_trap,
`endif
    output alu_seq_state_e seq_state
);

    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    alu_seq_state_e   state_q, state_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_q;
    alu_op_e          op_q;
    logic [7:0]       a_q, b_q;
    logic [DST_W-1:0] dst_q;
    logic [7:0]       data_q;
    alu_flag_e        flag_q;

`ifdef ALU_DIV0_TRAP_EN
    logic             trap_take;
    logic             trap_q;

    assign trap_take = (state_q == IDLE) && bus.req_valid &&
                       is_div_by_zero(bus.req_op, bus.req_b);
`endif

    // State register; reset drops any transaction in flight immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and request acceptance.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
`ifdef ALU_DIV0_TRAP_EN
                    state_d = trap_take ? RESP : EXEC;
`else
                    state_d = EXEC;
`endif
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand/op holding registers, latency counter and response capture.
    // Operands change only on the accept edge so the ALU flag logic, which
    // reads live inputs, sees the same values through capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            op_q   <= ALU_OP_RESET;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            dst_q  <= '0;
            data_q <= 8'h00;
            flag_q <= FLAG_NONE;
`ifdef ALU_DIV0_TRAP_EN
            trap_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q  <= bus.req_op;
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                dst_q <= bus.req_dst;
                cnt_q <= '0;
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q + CNT_ONE;
            end

            if (state_q == CAPTURE) begin
                data_q <= bus.alu_result;
                flag_q <= bus.alu_flag;
            end

`ifdef ALU_DIV0_TRAP_EN
            if (trap_take) begin
                data_q <= DIV0_RESULT;
                flag_q <= FLAG_REMAINDER;
            end
            trap_q <= trap_take;
`endif
        end
    end

    // State-decoded handshake/status outputs and held datapath values.
    assign bus.req_ready     = (state_q == IDLE);
    assign bus.alu_enable    = (state_q == CAPTURE);
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.busy          = (state_q != IDLE);
    assign bus.alu_register1 = a_q;
    assign bus.alu_register2 = b_q;
    assign bus.alu_op        = op_q;
    assign bus.rsp_data      = data_q;
    assign bus.rsp_flag      = flag_q;
    assign bus.rsp_dst       = dst_q;
    assign seq_state         = state_q;
`ifdef ALU_DIV0_TRAP_EN
    assign div0_trap         = trap_q;
`endif

endmodule
